tff_count_ctrl: RTL

- Upstream control stage for a bank of WIDTH toggle flip-flop cells. Each cell has inputs clr and t, samples on the falling clock edge, and behaves as follows: {clr,t}=10 clears, 00 holds, 01 toggles, 11 holds.
- Computes per-bit toggle requests so that the cell bank counts modulo MODULUS: up, down, parallel load and clear.
- Keeps a shadow copy of the bank value and flags wrap-around.
- Updates on the rising edge of clk, so its outputs are stable when the cells sample on the following falling edge.

---
 rtl/tff_count_ctrl_pkg.sv | 19 +
 rtl/tff_count_ctrl_if.sv | 28 ++
 rtl/tff_count_next.sv | 32 +++
 rtl/tff_count_ctrl.sv | 89 ++++++++
 4 files changed

// File: rtl/tff_count_ctrl_pkg.sv
// Shared constants for the toggle-flip-flop count controller.
//   WIDTH_DEF / MODULUS_DEF : default bank width and count modulus
//   DIR_UP / DIR_DN         : encodings of the direction input
//   cell_cmd_e              : {clr,t} command seen by one toggle cell
package tff_count_ctrl_pkg;

  localparam int WIDTH_DEF   = 4;
  localparam int MODULUS_DEF = 10;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [1:0] {
    CELL_HOLD = 2'b00,
    CELL_TGL  = 2'b01,
    CELL_CLR  = 2'b10
  } cell_cmd_e;

endpackage

// File: rtl/tff_count_ctrl_if.sv
// Bus between the count controller and its user/cell bank.
//   en, up, load, load_val : requests into the controller
//   t, cell_clr            : drive to the toggle cells
//   count, tc, load_err    : shadow value, wrap pulse, rejected-load pulse
// master = requester side, slave = controller side.
interface tff_count_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] t;
  logic             cell_clr;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             load_err;

  modport master (
    output en, up, load, load_val,
    input  t, cell_clr, count, tc, load_err
  );

  modport slave (
    input  en, up, load, load_val,
    output t, cell_clr, count, tc, load_err
  );
endinterface

// File: rtl/tff_count_next.sv
// Combinational next-value logic for a modulo-MODULUS up/down counter.
//   count_i : current count (always < MODULUS)
//   up_i    : direction (DIR_UP / DIR_DN)
//   next_o  : next count, always < MODULUS
//   wrap_o  : set when this step wraps (MODULUS-1 -> 0 up, 0 -> MODULUS-1 down)
module tff_count_next
  import tff_count_ctrl_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int MODULUS = MODULUS_DEF
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] next_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

  always_comb begin
    next_o = '0;
    wrap_o = 1'b0;
    if (up_i == DIR_UP) begin
      wrap_o = (count_i == TOP);
      next_o = wrap_o ? '0 : count_i + 1'b1;
    end else begin
      wrap_o = (count_i == '0);
      next_o = wrap_o ? TOP : count_i - 1'b1;
    end
  end

endmodule

// File: rtl/tff_count_ctrl.sv
// Control stage for a bank of WIDTH toggle cells that count modulo MODULUS.
// Cells sample {cell_clr, t[i]} on the falling edge; this block updates on
// the rising edge so its outputs are settled half a cycle before that.
//   clk : clock
//   clr : synchronous active-high reset
//   bus : tff_count_ctrl_if slave (en/up/load/load_val in;
//         t/cell_clr/count/tc/load_err out)
// Priority per rising edge: clr > load > en > idle.
module tff_count_ctrl
  import tff_count_ctrl_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int MODULUS = MODULUS_DEF
) (
  input  logic                  clk,
  input  logic                  clr,
  tff_count_ctrl_if.slave       bus
);

  // One extra bit so MODULUS == 2^WIDTH compares correctly.
  localparam logic [WIDTH:0] MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] t_q, t_d;
  logic             cell_clr_q, cell_clr_d;
  logic             tc_q, tc_d;
  logic             load_err_q, load_err_d;

  logic [WIDTH-1:0] next_cnt;
  logic             next_wrap;
  logic             load_ok;

  tff_count_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .count_i (count_q),
    .up_i    (bus.up),
    .next_o  (next_cnt),
    .wrap_o  (next_wrap)
  );

  assign load_ok = ({1'b0, bus.load_val} < MOD_EXT);

  // Toggle requests are the XOR of old and new value; a rejected load
  // swallows the cycle so en has no effect then.
  always_comb begin
    count_d    = count_q;
    t_d        = '0;
    cell_clr_d = 1'b0;
    tc_d       = 1'b0;
    load_err_d = 1'b0;
    if (clr) begin
      cell_clr_d = 1'b1;
      count_d    = '0;
    end else if (bus.load) begin
      if (load_ok) begin
        t_d     = count_q ^ bus.load_val;
        count_d = bus.load_val;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (bus.en) begin
      t_d     = count_q ^ next_cnt;
      count_d = next_cnt;
      tc_d    = next_wrap;
    end
  end

  always_ff @(posedge clk) begin
    count_q    <= count_d;
    t_q        <= t_d;
    cell_clr_q <= cell_clr_d;
    tc_q       <= tc_d;
    load_err_q <= load_err_d;
  end

  assign bus.count    = count_q;
  assign bus.t        = t_q;
  assign bus.cell_clr = cell_clr_q;
  assign bus.tc       = tc_q;
  assign bus.load_err = load_err_q;

  // {clr,t}=11 holds in the cell instead of clearing it.
  a_no_toggle_during_clear: assert property (
    @(posedge clk) !(cell_clr_q && (t_q != '0))
  );

endmodule
